// File: rtl/serial_addsub.sv
// serial_addsub
// Digit-serial adder/subtractor. Operands are captured on a start pulse and
// consumed DIGIT bits per clock, LSB slice first, with the borrow/carry
// carried between slices in a register. Results and flags are registered at
// completion and held until the next completion or reset.
//
// Ports:
//   i_clk    - clock, all state changes on the rising edge
//   i_rst    - synchronous active-high reset
//   i_start  - operation request, only looked at while idle
//   i_mode   - 1 = a - b - bin, 0 = a + b + bin
//   i_a      - minuend / addend A
//   i_b      - subtrahend / addend B
//   i_bin    - borrow-in (subtract) / carry-in (add)
//   o_busy   - high while slices are being processed
//   o_done   - one-cycle pulse, results valid from this cycle
//   o_diff   - result, modulo 2^WIDTH
//   o_bout   - final borrow-out (subtract) / carry-out (add)
//   o_ovf    - two's-complement signed overflow
//   o_zero   - o_diff == 0
//
// WIDTH must be an integer multiple of DIGIT, with 1 <= DIGIT <= WIDTH.

module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_mode;
  logic             r_c;
  logic             r_aMsb;
  logic             r_bMsb;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT-1:0] w_slice;
  logic             w_cout;
  logic [WIDTH-1:0] w_sliceWide;
  logic [WIDTH-1:0] w_nextRes;
  logic             w_ovf;

  // One slice of full-subtractor / full-adder cells. The borrow/carry ripples
  // from bit 0 upward inside the slice; w_cout is the slice carry that gets
  // registered for the next step.
  always_comb begin
    w_slice = '0;
    w_cout  = r_c;
    for (int i = 0; i < DIGIT; i++) begin
      w_slice[i] = r_a[i] ^ r_b[i] ^ w_cout;
      if (r_mode) begin
        w_cout = (~r_a[i] & r_b[i]) | (~r_a[i] & w_cout) | (r_b[i] & w_cout);
      end else begin
        w_cout = (r_a[i] & r_b[i]) | (r_a[i] & w_cout) | (r_b[i] & w_cout);
      end
    end
  end

  // The result register fills from the top: each new slice enters at the MSB
  // end and earlier slices move down, so after STEPS slices the first one
  // sits at bit 0. The shift form also covers DIGIT == WIDTH without an
  // empty part-select.
  assign w_sliceWide = WIDTH'(w_slice);
  assign w_nextRes   = (r_res >> DIGIT) | (w_sliceWide << (WIDTH - DIGIT));

  // Overflow uses the sign bits captured at start, since the operand shift
  // registers no longer hold them by the final step.
  assign w_ovf = r_mode ? ((r_aMsb != r_bMsb) && (w_nextRes[WIDTH-1] != r_aMsb))
                        : ((r_aMsb == r_bMsb) && (w_nextRes[WIDTH-1] != r_aMsb));

  // Control FSM and datapath registers. Outputs are registered here so that
  // busy/done and the flags all change on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_mode  <= 1'b0;
      r_c     <= 1'b0;
      r_aMsb  <= 1'b0;
      r_bMsb  <= 1'b0;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_diff  <= '0;
      o_bout  <= 1'b0;
      o_ovf   <= 1'b0;
      o_zero  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_mode  <= i_mode;
            r_c     <= i_bin;
            r_aMsb  <= i_a[WIDTH-1];
            r_bMsb  <= i_b[WIDTH-1];
            r_res   <= '0;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_c   <= w_cout;
          r_res <= w_nextRes;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_state <= IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_diff  <= w_nextRes;
            o_bout  <= w_cout;
            o_ovf   <= w_ovf;
            o_zero  <= (w_nextRes == '0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
// Bench for serial_addsub. Five instances share one clock and reset:
//   0: WIDTH=8 DIGIT=1   1: WIDTH=8 DIGIT=4
//   2: WIDTH=4 DIGIT=1   3: WIDTH=4 DIGIT=2   4: WIDTH=4 DIGIT=4
// Expected results are queued when a start is driven and taken off the queue
// by a monitor whenever an instance raises done.

module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic       sStart[5];
  logic       sMode[5];
  logic       sBin[5];
  logic [7:0] sA[5];
  logic [7:0] sB[5];

  logic       busy0, done0, bout0, ovf0, zero0;
  logic [7:0] diff0;
  logic       busy1, done1, bout1, ovf1, zero1;
  logic [7:0] diff1;
  logic       busy2, done2, bout2, ovf2, zero2;
  logic [3:0] diff2;
  logic       busy3, done3, bout3, ovf3, zero3;
  logic [3:0] diff3;
  logic       busy4, done4, bout4, ovf4, zero4;
  logic [3:0] diff4;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(sStart[0]), .i_mode(sMode[0]),
    .i_a(sA[0]), .i_b(sB[0]), .i_bin(sBin[0]),
    .o_busy(busy0), .o_done(done0), .o_diff(diff0), .o_bout(bout0),
    .o_ovf(ovf0), .o_zero(zero0));

  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(sStart[1]), .i_mode(sMode[1]),
    .i_a(sA[1]), .i_b(sB[1]), .i_bin(sBin[1]),
    .o_busy(busy1), .o_done(done1), .o_diff(diff1), .o_bout(bout1),
    .o_ovf(ovf1), .o_zero(zero1));

  serial_addsub #(.WIDTH(4), .DIGIT(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(sStart[2]), .i_mode(sMode[2]),
    .i_a(sA[2][3:0]), .i_b(sB[2][3:0]), .i_bin(sBin[2]),
    .o_busy(busy2), .o_done(done2), .o_diff(diff2), .o_bout(bout2),
    .o_ovf(ovf2), .o_zero(zero2));

  serial_addsub #(.WIDTH(4), .DIGIT(2)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(sStart[3]), .i_mode(sMode[3]),
    .i_a(sA[3][3:0]), .i_b(sB[3][3:0]), .i_bin(sBin[3]),
    .o_busy(busy3), .o_done(done3), .o_diff(diff3), .o_bout(bout3),
    .o_ovf(ovf3), .o_zero(zero3));

  serial_addsub #(.WIDTH(4), .DIGIT(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(sStart[4]), .i_mode(sMode[4]),
    .i_a(sA[4][3:0]), .i_b(sB[4][3:0]), .i_bin(sBin[4]),
    .o_busy(busy4), .o_done(done4), .o_diff(diff4), .o_bout(bout4),
    .o_ovf(ovf4), .o_zero(zero4));

  int stepsOf[5] = '{8, 2, 4, 2, 1};
  int widthOf[5] = '{8, 8, 4, 4, 4};

  typedef struct {
    int         inst;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
    int         doneCyc;
  } exp_t;

  typedef struct {
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
  } vec_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  // Free-running cycle count used to check done latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: plain integer arithmetic reduced to the instance width.
  function automatic exp_t model(input int k, input logic mode, input logic [7:0] a,
                                 input logic [7:0] b, input logic bin);
    exp_t e;
    int   w, mask, ai, bi, r, am, bm, dm;
    w    = widthOf[k];
    mask = (1 << w) - 1;
    ai   = int'(a) & mask;
    bi   = int'(b) & mask;
    r    = mode ? (ai - bi - int'(bin)) : (ai + bi + int'(bin));
    e.inst = k;
    e.diff = 8'(r & mask);
    e.bout = mode ? (r < 0) : (r > mask);
    am     = (ai >> (w - 1)) & 1;
    bm     = (bi >> (w - 1)) & 1;
    dm     = (int'(e.diff) >> (w - 1)) & 1;
    e.ovf  = mode ? ((am != bm) && (dm != am)) : ((am == bm) && (dm != am));
    e.zero = (e.diff == 8'h00);
    e.doneCyc = 0;
    return e;
  endfunction

  // Queue an expectation for a start driven in the current cycle.
  task automatic pushExp(input exp_t e);
    exp_t q;
    q = e;
    q.doneCyc = cyc + 1 + stepsOf[q.inst];
    sb.push_back(q);
  endtask

  // Drive a one-cycle start; returns at the next falling edge.
  task automatic applyStimulus(input int k, input logic mode, input logic [7:0] a,
                               input logic [7:0] b, input logic bin);
    sMode[k]  = mode;
    sA[k]     = a;
    sB[k]     = b;
    sBin[k]   = bin;
    sStart[k] = 1'b1;
    @(negedge clk);
    sStart[k] = 1'b0;
  endtask

  function automatic int pending(input int k);
    int n;
    n = 0;
    for (int i = 0; i < sb.size(); i++) if (sb[i].inst == k) n++;
    return n;
  endfunction

  task automatic waitIdle(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (pending(k) != 0 && n < 40);
    if (pending(k) != 0) failNow($sformatf("timeout waiting for done inst%0d", k));
  endtask

  task automatic seeDone(input int k, input logic dn, input logic [7:0] d,
                         input logic bo, input logic ov, input logic ze);
    int   idx;
    exp_t e;
    if (dn === 1'b1) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].inst == k) idx = i;
      if (idx < 0) begin
        failNow($sformatf("unexpected done inst%0d", k));
      end else begin
        e = sb[idx];
        sb.delete(idx);
        checkOutput($sformatf("diff inst%0d", k), d, e.diff);
        checkOutput($sformatf("bout inst%0d", k), bo, e.bout);
        checkOutput($sformatf("ovf inst%0d", k), ov, e.ovf);
        checkOutput($sformatf("zero inst%0d", k), ze, e.zero);
        checkOutput($sformatf("latency inst%0d", k), cyc, e.doneCyc);
      end
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending
  // expectation for that instance, at exactly the expected cycle.
  always @(negedge clk) begin
    seeDone(0, done0, diff0, bout0, ovf0, zero0);
    seeDone(1, done1, diff1, bout1, ovf1, zero1);
    seeDone(2, done2, {4'h0, diff2}, bout2, ovf2, zero2);
    seeDone(3, done3, {4'h0, diff3}, bout3, ovf3, zero3);
    seeDone(4, done4, {4'h0, diff4}, bout4, ovf4, zero4);
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, busy0, 1'b0);
    checkOutput({tag, " done"}, done0, 1'b0);
    checkOutput({tag, " diff"}, diff0, 8'h00);
    checkOutput({tag, " bout"}, bout0, 1'b0);
    checkOutput({tag, " ovf"}, ovf0, 1'b0);
    checkOutput({tag, " zero"}, zero0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[10];
    exp_t e;
    int   n;

    vecs[0] = '{1'b1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h03, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 8'h9C, 8'h3E, 1'b0, 8'h5E, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};

    for (int k = 0; k < 5; k++) begin
      sStart[k] = 1'b0;
      sMode[k]  = 1'b0;
      sBin[k]   = 1'b0;
      sA[k]     = 8'h00;
      sB[k]     = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Table vectors on the bit-serial instance; the first one also traces busy.
    $display("[TB] table vectors, WIDTH=8 DIGIT=1");
    for (int i = 0; i < 10; i++) begin
      waitIdle(0);
      e = '{0, vecs[i].diff, vecs[i].bout, vecs[i].ovf, vecs[i].zero, 0};
      pushExp(e);
      applyStimulus(0, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].bin);
      if (i == 0) begin
        checkOutput("busy after E0", busy0, 1'b1);
        for (int j = 1; j <= 8; j++) begin
          @(negedge clk);
          checkOutput($sformatf("busy after E%0d", j), busy0, (j < 8) ? 1'b1 : 1'b0);
        end
      end
    end
    waitIdle(0);

    // Same table on DIGIT=4, each new start issued in the done cycle.
    $display("[TB] table vectors back-to-back, WIDTH=8 DIGIT=4");
    for (int i = 0; i < 10; i++) begin
      e = '{1, vecs[i].diff, vecs[i].bout, vecs[i].ovf, vecs[i].zero, 0};
      pushExp(e);
      applyStimulus(1, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].bin);
      n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (done1 !== 1'b1 && n < 20);
      if (done1 !== 1'b1) failNow("timeout waiting for done1");
    end
    waitIdle(1);

    // start re-pulsed mid-RUN with other operands must be ignored.
    $display("[TB] start while busy");
    waitIdle(0);
    pushExp(model(0, 1'b1, 8'h40, 8'h01, 1'b0));
    applyStimulus(0, 1'b1, 8'h40, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    applyStimulus(0, 1'b0, 8'hFF, 8'h00, 1'b1);
    waitIdle(0);
    repeat (12) @(negedge clk);

    // Reset at step 4 of 8: outputs clear, no done for the aborted operation.
    $display("[TB] reset mid-run");
    applyStimulus(0, 1'b1, 8'h55, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("mid-run reset");
    #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    pushExp(model(0, 1'b1, 8'h55, 8'h11, 1'b0));
    applyStimulus(0, 1'b1, 8'h55, 8'h11, 1'b0);
    waitIdle(0);

    // rst and start at the same edge: reset wins.
    $display("[TB] reset with start");
    rst = 1'b1;
    sStart[0] = 1'b1;
    sA[0] = 8'h22;
    sB[0] = 8'h11;
    @(negedge clk);
    checkOutput("busy after rst+start", busy0, 1'b0);
    #1;
    rst = 1'b0;
    sStart[0] = 1'b0;
    repeat (12) @(negedge clk);

    // Exhaustive WIDTH=4 sweep for each digit size.
    for (int k = 2; k < 5; k++) begin
      $display("[TB] exhaustive WIDTH=4 DIGIT=%0d", widthOf[k] / stepsOf[k]);
      for (int m = 0; m < 2; m++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++) begin
              waitIdle(k);
              pushExp(model(k, 1'(m), 8'(a), 8'(b), 1'(c)));
              applyStimulus(k, 1'(m), 8'(a), 8'(b), 1'(c));
            end
      waitIdle(k);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised digit-serial adder/subtractor, the multi-bit, clocked successor to the single-bit full subtractor. It accepts two WIDTH-bit operands plus a borrow/carry-in on a start pulse. It processes DIGIT bits per clock, LSB digit first, using full-subtractor (or full-adder) equations per bit. It returns the registered result with borrow/carry, signed-overflow and zero flags, and a one-cycle done pulse. It is intended for area-constrained datapaths where one wide combinational subtractor is too large.

Parameters:
WIDTH, 8, operand/result width in bits; must be an integer multiple of DIGIT.
DIGIT, 1, bits processed per RUN cycle; 1 <= DIGIT <= WIDTH.
(Derived) STEPS = WIDTH/DIGIT; the step counter is max(1, clog2(STEPS)) bits.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
mode  input  1  1 = subtract (a - b - bin), 0 = add (a + b + bin); captured with operands.
a  input  WIDTH  minuend / addend A.
b  input  WIDTH  subtrahend / addend B.
bin  input  1  borrow-in (sub) / carry-in (add).
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; results are valid from this cycle.
diff  output  WIDTH  result.
bout  output  1  final borrow-out (sub) / carry-out (add).
ovf  output  1  two's-complement signed overflow.
zero  output  1  diff == 0.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, step count=0, internal borrow=0. All outputs (busy, done, diff, bout, ovf, zero) are 0. Any in-flight operation is discarded and no done is produced for it.
- States:
  - IDLE: start=1 at edge E0 latches a, b, mode into shift registers and bin into the borrow register. Step count=0, next state RUN.
  - RUN: each edge processes one DIGIT-wide slice, LSB slice first.
  - Per bit (sub): d = x^y^c; c' = (~x&y)|(~x&c)|(y&c).
  - Per bit (add): s = x^y^c; c' = (x&y)|(x&c)|(y&c).
  - Within a slice, the borrow/carry ripples combinationally from bit 0 to bit DIGIT-1. The slice output carry is registered for the next step.
- Latency: the slice-processing edges are E1..E_STEPS. At E_STEPS the state returns to IDLE and diff, bout, ovf, zero are registered; done=1 for the following cycle only, deasserting at E_STEPS+1. busy=1 from after E0 through E_STEPS.
- Back-to-back operation: start is accepted in the cycle where done=1, because state is already IDLE. The next done follows exactly STEPS cycles later.
- start while busy is ignored: operands are not reloaded and no extra done is generated.
- a, b, bin, mode may change freely during RUN with no effect on the result.
- Output hold: diff, bout, ovf, zero hold their values until the next completion or reset. They are not cleared on a new start.
- ovf (sub) = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- ovf (add) = (a[MSB] == b[MSB]) && (diff[MSB] != a[MSB]).
- Both ovf forms use the latched operands.
- Wrap-around: the result is modulo 2^WIDTH; bout carries the out-of-range indication.
- DIGIT == WIDTH: STEPS=1, giving a single RUN cycle and done one cycle after E0.
- rst and start asserted at the same edge: reset wins and the state stays IDLE.

Test Plan:
- WIDTH=8, DIGIT=1, sub: a=0x05, b=0x03, bin=0, start at E0 -> busy for 8 cycles; done at E8 with diff=0x02, bout=0, ovf=0, zero=0.
- Sub underflow and borrow-in:
  - a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
  - a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
  - a=0x03, b=0x03, bin=0 -> diff=0x00, zero=1.
- Overflow:
  - Sub a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0.
  - Add (mode=0) a=0x7F, b=0x01, bin=0 -> diff=0x80, ovf=1, bout=0.
  - Add a=0xFF, b=0x01 -> diff=0x00, bout=1, zero=1.
- WIDTH=8, DIGIT=4:
  - a=0x9C, b=0x3E sub -> done exactly 2 cycles after start, diff=0x5E.
  - A second start issued in the done cycle completes 2 cycles later.
- Protocol:
  - start re-pulsed mid-RUN with different operands -> result matches the first operands and only one done is produced.
  - rst asserted at step 4 of 8 -> all outputs 0 next cycle, no done; a fresh start afterwards completes normally.
- Exhaustive, WIDTH=4 with DIGIT in {1, 2, 4}: every a, b, bin, mode combination is checked against the reference model (a ∓ b ∓ bin) mod 16. The bench also checks bout, ovf, zero, and that the latency equals STEPS.
